fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage directly upstream of IMEM and decode. Owns the PC register, drives
//   IMEM_PC, captures the returned word into a small FIFO and hands {pc, instr} to decode over a
//   valid/ready handshake. Supports PC load from the system port, branch redirect with flush,
//   and a halt sentinel.
// PARAMETERS
//   PC_W       8              PC width; matches IMEM_PC.
//   DEPTH      2              Fetch-buffer entries; power of two, >=2.
//   RESET_PC   8'h00          PC value after reset.
//   HALT_WORD  32'hFFFF_FFFF  Instruction word that halts fetch.
// PORTS
//   SYS_clk             in   1      Clock, rising edge.
//   SYS_reset           in   1      Asynchronous, active-low reset.
//   SYS_load            in   1      Load PC from SYS_pc_val, flush buffer, enter RUN.
//   SYS_pc_val          in   PC_W   PC value used by SYS_load.
//   FE_branch_taken     in   1      Redirect request from execute.
//   FE_branch_target    in   PC_W   Redirect PC.
//   FE_imem_pc          out  PC_W   Address to IMEM; equals PC register.
//   FE_imem_instruction in   32     IMEM read data; combinational from FE_imem_pc.
//   FE_out_valid        out  1      Head entry valid.
//   FE_out_ready        in   1      Decode accepts head entry.
//   FE_out_instruction  out  32     Head entry instruction.
//   FE_out_pc           out  PC_W   Head entry PC.
//   FE_out_pc_plus4     out  PC_W   Head entry PC+4, mod 2^PC_W.
//   FE_halted           out  1      High in HALT state.
// BEHAVIOUR
//   Reset (async, SYS_reset=0):
//   - PC=RESET_PC, buffer empty, state IDLE.
//   - All outputs 0, except FE_imem_pc=RESET_PC.
//   States:
//   - IDLE: no fetch.
//   - RUN: fetch.
//   - HALT: no fetch; buffer continues to drain.
//   Transitions:
//   - Any state -> RUN on SYS_load.
//   - RUN -> HALT when HALT_WORD is pushed. The sentinel is itself delivered to decode.
//   Per-cycle priority (highest first):
//   - SYS_load: PC<=SYS_pc_val with bits[1:0] forced 0, buffer flushed, no push.
//   - FE_branch_taken (RUN/HALT only): PC<=FE_branch_target with [1:0] forced 0, buffer flushed,
//     no push, state->RUN. Ignored in IDLE.
//   - Fetch (RUN only): push {PC, FE_imem_instruction} when count<DEPTH, or when count==DEPTH
//     and a pop occurs the same cycle; then PC<=PC+4. Otherwise PC holds.
//   Pop: FE_out_valid && FE_out_ready. Outputs always reflect the head entry, registered.
//   FE_out_valid = (count!=0).
//   Latency: first entry valid 1 cycle after the SYS_load cycle, plus 1 cycle to fetch
//     (load at edge N, push at edge N+1, valid after N+1).
//   Throughput: 1 instr/cycle with FE_out_ready held high.
//   Flush: on the flush cycle, count<=0 and any simultaneous pop is discarded;
//     FE_out_valid=0 the following cycle.
//   Full with no pop: PC and buffer hold; the IMEM word is re-read next cycle.
//   Empty with FE_out_ready=1: no pop; the output fields hold their last value.
//   Wrap: PC+4 and pc_plus4 wrap modulo 2^PC_W (8'hFC -> 8'h00), no flag.
//   Pointers: DEPTH-entry circular buffer, log2(DEPTH) read/write pointers;
//     count is 0..DEPTH, (log2(DEPTH)+1) bits.
//   Reset mid-operation: immediate return to reset values; no partial entry survives.
// TESTING
//   1. Reset, SYS_load with pc_val=8'h10, ready=1, IMEM=pc-tagged words -> entries pc 10,14,18,...
//      one per cycle; pc_plus4=14,18,1C.
//   2. ready=0 after load -> exactly DEPTH entries (pc 10,14); PC holds at 18. ready=1 ->
//      10,14,18 in order, no gap, no duplicate.
//   3. branch_taken target=8'h41 while buffer holds 2 entries -> valid=0 next cycle, then pc 40
//      first; a same-cycle pop is discarded.
//   4. load 8'hF8 -> pcs F8, FC, 00, 04 (wrap).
//   5. HALT_WORD at pc 0C -> word delivered, halted=1, no further fetch; SYS_load 8'h00 resumes
//      from 00.
//   6. SYS_reset low mid-stream with buffer full -> valid=0 and imem_pc=00 immediately
//      (asynchronous), IDLE held until SYS_load.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one IMEM word per cycle into a small
// circular buffer and presents the head entry to decode over valid/ready.
module fetch_unit #(
    parameter int              PC_W      = 8,
    parameter int              DEPTH     = 2,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic            SYS_clk,
    input  logic            SYS_reset,
    input  logic            SYS_load,
    input  logic [PC_W-1:0] SYS_pc_val,
    input  logic            FE_branch_taken,
    input  logic [PC_W-1:0] FE_branch_target,
    output logic [PC_W-1:0] FE_imem_pc,
    input  logic [31:0]     FE_imem_instruction,
    output logic            FE_out_valid,
    input  logic            FE_out_ready,
    output logic [31:0]     FE_out_instruction,
    output logic [PC_W-1:0] FE_out_pc,
    output logic [PC_W-1:0] FE_out_pc_plus4,
    output logic            FE_halted
);
    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0] PC_MASK  = {{(PC_W-2){1'b1}}, 2'b00};
    localparam logic [PC_W-1:0] PC_STEP  = PC_W'(4);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t            r_state, w_state_nxt;
    logic              w_fetch_en, w_halted;

    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_mem_pc  [DEPTH];
    logic [31:0]       r_mem_ins [DEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic [PC_W-1:0]   r_out_pc, r_out_pc4;
    logic [31:0]       r_out_ins;

    logic              w_branch, w_flush, w_pop, w_pop_eff, w_push;
    logic [PTR_W-1:0]  w_rptr_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_head_byp;
    logic [PC_W-1:0]   w_head_pc;
    logic [31:0]       w_head_ins;

    // Redirects are only honoured once fetch has been started by a load.
    assign w_branch  = FE_branch_taken && (r_state != S_IDLE);
    assign w_flush   = SYS_load || w_branch;
    assign w_pop     = (r_count != '0) && FE_out_ready;
    assign w_pop_eff = w_pop && !w_flush;
    assign w_push    = w_fetch_en && !w_flush && ((r_count != FULL_CNT) || w_pop);

    // ---------------- FSM ----------------
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (SYS_load || w_branch)
            w_state_nxt = S_RUN;
        else if (w_push && (FE_imem_instruction == HALT_WORD))
            w_state_nxt = S_HALT;
    end

    always_comb begin
        w_fetch_en = (r_state == S_RUN);
        w_halted   = (r_state == S_HALT);
    end

    // ---------------- PC ----------------
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset)    r_pc <= RESET_PC;
        else if (SYS_load) r_pc <= SYS_pc_val & PC_MASK;
        else if (w_branch) r_pc <= FE_branch_target & PC_MASK;
        else if (w_push)   r_pc <= r_pc + PC_STEP;
    end

    // ---------------- buffer ----------------
    assign w_rptr_nxt = r_rptr + PTR_W'(w_pop_eff);
    assign w_cnt_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop_eff);

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(w_push);
            r_rptr  <= w_rptr_nxt;
            r_count <= w_cnt_nxt;
        end
    end

    always_ff @(posedge SYS_clk) begin
        if (w_push) begin
            r_mem_pc[r_wptr]  <= r_pc;
            r_mem_ins[r_wptr] <= FE_imem_instruction;
        end
    end

    // A push landing on the next read slot means the buffer was empty after any pop,
    // so the incoming word becomes the head directly.
    assign w_head_byp = w_push && (r_wptr == w_rptr_nxt);
    assign w_head_pc  = w_head_byp ? r_pc : r_mem_pc[w_rptr_nxt];
    assign w_head_ins = w_head_byp ? FE_imem_instruction : r_mem_ins[w_rptr_nxt];

    // Head fields are registered and hold their last value while the buffer is empty.
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            r_out_pc  <= '0;
            r_out_pc4 <= '0;
            r_out_ins <= '0;
        end else if (!w_flush && (w_cnt_nxt != '0)) begin
            r_out_pc  <= w_head_pc;
            r_out_pc4 <= w_head_pc + PC_STEP;
            r_out_ins <= w_head_ins;
        end
    end

    assign FE_imem_pc         = r_pc;
    assign FE_out_valid       = (r_count != '0);
    assign FE_out_pc          = r_out_pc;
    assign FE_out_pc_plus4    = r_out_pc4;
    assign FE_out_instruction = r_out_ins;
    assign FE_halted          = w_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_fetch_unit;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] ins;
    } ent_t;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset = 1'b0;
    logic        SYS_load = 1'b0;
    logic [7:0]  SYS_pc_val = '0;
    logic        FE_branch_taken = 1'b0;
    logic [7:0]  FE_branch_target = '0;
    logic [7:0]  FE_imem_pc;
    logic [31:0] FE_imem_instruction;
    logic        FE_out_valid;
    logic        FE_out_ready = 1'b0;
    logic [31:0] FE_out_instruction;
    logic [7:0]  FE_out_pc;
    logic [7:0]  FE_out_pc_plus4;
    logic        FE_halted;

    int checks = 0;
    int failures = 0;

    logic       halt_en = 1'b0;
    logic [7:0] halt_pc = '0;

    fetch_unit dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .SYS_load(SYS_load), .SYS_pc_val(SYS_pc_val),
        .FE_branch_taken(FE_branch_taken), .FE_branch_target(FE_branch_target),
        .FE_imem_pc(FE_imem_pc), .FE_imem_instruction(FE_imem_instruction),
        .FE_out_valid(FE_out_valid), .FE_out_ready(FE_out_ready),
        .FE_out_instruction(FE_out_instruction), .FE_out_pc(FE_out_pc),
        .FE_out_pc_plus4(FE_out_pc_plus4), .FE_halted(FE_halted)
    );

    always #5 SYS_clk = ~SYS_clk;

    function automatic logic [31:0] imem_word(input logic [7:0] pc, input logic hen, input logic [7:0] hpc);
        if (hen && pc == hpc) return HALT_WORD;
        return {16'hC0DE, ~pc, pc};
    endfunction

    always_comb FE_imem_instruction = imem_word(FE_imem_pc, halt_en, halt_pc);

    logic [57:0] dut_vec;
    assign dut_vec = {FE_out_valid, FE_out_pc, FE_out_pc_plus4, FE_out_instruction, FE_imem_pc, FE_halted};

    // Reference model: 0=IDLE 1=RUN 2=HALT, queue of fetched entries, last head fields.
    int          m_state;
    logic [7:0]  m_pc;
    ent_t        m_q[$];
    logic [7:0]  m_hpc, m_hpc4;
    logic [31:0] m_hins;

    task automatic model_reset();
        m_state = 0; m_pc = 8'h00; m_q.delete();
        m_hpc = '0; m_hpc4 = '0; m_hins = '0;
    endtask

    task automatic model_step(input logic ld, input logic [7:0] pcv, input logic br,
                              input logic [7:0] tgt, input logic rdy);
        int sz;
        logic pop;
        logic [31:0] w;
        sz  = m_q.size();
        pop = (sz != 0) && rdy;
        if (ld) begin
            m_pc = {pcv[7:2], 2'b00}; m_q.delete(); m_state = 1;
        end else if (br && m_state != 0) begin
            m_pc = {tgt[7:2], 2'b00}; m_q.delete(); m_state = 1;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_state == 1 && (sz < DEPTH || pop)) begin
                w = imem_word(m_pc, halt_en, halt_pc);
                m_q.push_back('{pc: m_pc, ins: w});
                if (w == HALT_WORD) m_state = 2;
                m_pc = m_pc + 8'd4;
            end
        end
        if (m_q.size() != 0) begin
            m_hpc = m_q[0].pc; m_hpc4 = m_q[0].pc + 8'd4; m_hins = m_q[0].ins;
        end
    endtask

    function automatic logic [57:0] exp_vec();
        return {m_q.size() != 0, m_hpc, m_hpc4, m_hins, m_pc, m_state == 2};
    endfunction

    task automatic cycle(input logic ld, input logic [7:0] pcv, input logic br,
                         input logic [7:0] tgt, input logic rdy);
        SYS_load = ld; SYS_pc_val = pcv; FE_branch_taken = br; FE_branch_target = tgt;
        FE_out_ready = rdy;
        @(posedge SYS_clk);
        model_step(ld, pcv, br, tgt, rdy);
        #1;
    endtask

    task automatic test_reset();
        SYS_reset = 1'b0;
        model_reset();
        #2;
        checks++;
        if (dut_vec !== 58'h0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, 58'h0);
        end
        @(negedge SYS_clk);
        SYS_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 8'h80, 1'b1);
            checks++;
            if (dut_vec !== 58'h0) begin
                failures++; $display("FAIL reset_idle_hold k=%0d got=%h exp=%h", k, dut_vec, 58'h0);
            end
        end
    endtask

    task automatic test_stream();
        cycle(1'b1, 8'h10, 1'b0, 8'h00, 1'b1);
        checks++;
        if (FE_out_valid !== 1'b0 || FE_imem_pc !== 8'h10) begin
            failures++; $display("FAIL stream_load valid=%b pc=%h exp valid=0 pc=10", FE_out_valid, FE_imem_pc);
        end
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL stream_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
            if (k < 4) begin
                checks++;
                if ({FE_out_valid, FE_out_pc, FE_out_pc_plus4} !== {1'b1, 8'h10 + 8'(4*k), 8'h14 + 8'(4*k)}) begin
                    failures++;
                    $display("FAIL stream_seq k=%0d got v=%b pc=%h pc4=%h exp pc=%h", k, FE_out_valid,
                             FE_out_pc, FE_out_pc_plus4, 8'h10 + 8'(4*k));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        cycle(1'b1, 8'h10, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL bp_fill k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
        checks++;
        if ({FE_out_valid, FE_out_pc, FE_imem_pc} !== {1'b1, 8'h10, 8'h18}) begin
            failures++; $display("FAIL bp_full got v=%b pc=%h imem_pc=%h exp 1/10/18", FE_out_valid, FE_out_pc, FE_imem_pc);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({FE_out_valid, FE_out_pc} !== {1'b1, 8'h10 + 8'(4*k)}) begin
                failures++; $display("FAIL bp_drain k=%0d got v=%b pc=%h exp pc=%h", k, FE_out_valid, FE_out_pc, 8'h10 + 8'(4*k));
            end
            cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL bp_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_branch();
        cycle(1'b1, 8'h10, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 8'h41, 1'b1);
        checks++;
        if ({FE_out_valid, FE_imem_pc} !== {1'b0, 8'h40} || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL branch_flush got v=%b pc=%h exp v=0 pc=40", FE_out_valid, FE_imem_pc);
        end
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({FE_out_valid, FE_out_pc} !== {1'b1, 8'h40} || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL branch_first got v=%b pc=%h exp v=1 pc=40", FE_out_valid, FE_out_pc);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 8'hF8, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            checks++;
            if ({FE_out_pc, FE_out_pc_plus4} !== {8'hF8 + 8'(4*k), 8'hFC + 8'(4*k)} || dut_vec !== exp_vec()) begin
                failures++; $display("FAIL wrap k=%0d got pc=%h pc4=%h exp pc=%h", k, FE_out_pc, FE_out_pc_plus4, 8'hF8 + 8'(4*k));
            end
        end
    endtask

    task automatic test_halt();
        halt_en = 1'b1; halt_pc = 8'h0C;
        cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({FE_out_valid, FE_out_pc, FE_out_instruction, FE_halted} !== {1'b1, 8'h0C, HALT_WORD, 1'b1}) begin
            failures++; $display("FAIL halt_deliver got v=%b pc=%h ins=%h h=%b exp 1/0C/FFFFFFFF/1",
                                 FE_out_valid, FE_out_pc, FE_out_instruction, FE_halted);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            checks++;
            if ({FE_out_valid, FE_imem_pc, FE_halted} !== {1'b0, 8'h10, 1'b1} || dut_vec !== exp_vec()) begin
                failures++; $display("FAIL halt_stop k=%0d got v=%b pc=%h h=%b exp 0/10/1", k, FE_out_valid, FE_imem_pc, FE_halted);
            end
        end
        halt_en = 1'b0;
        cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({FE_out_valid, FE_out_pc, FE_halted} !== {1'b1, 8'h00, 1'b0} || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL halt_resume got v=%b pc=%h h=%b exp 1/00/0", FE_out_valid, FE_out_pc, FE_halted);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 8'h20, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge SYS_clk);
        #2;
        SYS_reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({FE_out_valid, FE_imem_pc, FE_halted} !== {1'b0, 8'h00, 1'b0}) begin
            failures++; $display("FAIL async_reset got v=%b pc=%h h=%b exp 0/00/0", FE_out_valid, FE_imem_pc, FE_halted);
        end
        @(negedge SYS_clk);
        SYS_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            checks++;
            if ({FE_out_valid, FE_imem_pc} !== {1'b0, 8'h00} || dut_vec !== exp_vec()) begin
                failures++; $display("FAIL reset_idle k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic ld, br, rdy;
        logic [7:0] pcv, tgt;
        halt_en = 1'b1; halt_pc = 8'h3C;
        cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 400; k++) begin
            ld  = ($urandom % 32) == 0;
            br  = ($urandom % 16) == 0;
            rdy = ($urandom % 4) != 0;
            pcv = 8'($urandom);
            tgt = 8'($urandom);
            cycle(ld, pcv, br, tgt, rdy);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
        halt_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_wrap();
        test_halt();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
